// File: rtl/linterp_pkg.sv
// Shared types and constants for the linterp sequencer and its bench.
package linterp_pkg;

    typedef enum logic [1:0] {EMPTY, LOADING, PLAY, DRAIN} ctrl_state_t;

    // Cycles from accepting the last burst sample to the first valid banked dout.
    localparam int LOAD_LAT = 3;

endpackage

// File: rtl/linterp_ctrl_if.sv
// IFFT sample stream in, linterp write/read controls out, plus status.
interface linterp_ctrl_if #(
    parameter int dwidth = 16,
    parameter int Nfft   = 32,
    parameter int iwidth = $clog2(Nfft),
    parameter int cwidth = 16
);
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [dwidth-1:0] s_real;
    logic [dwidth-1:0] s_imag;
    logic              out_strobe;
    logic              dv_in;
    logic [iwidth-1:0] index_in;
    logic [dwidth-1:0] din_real;
    logic [dwidth-1:0] din_imag;
    logic [iwidth-1:0] index_out;
    logic              out_valid;
    logic              err_len;
    logic [cwidth-1:0] underrun_cnt;

    modport master (
        output s_valid, s_last, s_real, s_imag, out_strobe,
        input  s_ready, dv_in, index_in, din_real, din_imag,
               index_out, out_valid, err_len, underrun_cnt
    );

    modport slave (
        input  s_valid, s_last, s_real, s_imag, out_strobe,
        output s_ready, dv_in, index_in, din_real, din_imag,
               index_out, out_valid, err_len, underrun_cnt
    );
endinterface

// File: rtl/linterp_ctrl.sv
// Sequences IFFT bursts into linterp's latch and bank, and paces playout
// of the banked burst at the output sample rate.
module linterp_ctrl
    import linterp_pkg::*;
#(
    parameter int dwidth = 16,
    parameter int Nfft   = 32,
    parameter int iwidth = $clog2(Nfft),
    parameter int cwidth = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    linterp_ctrl_if.slave bus
);

    localparam logic [iwidth-1:0] LAST_IDX  = iwidth'(Nfft - 1);
    localparam logic [1:0]        LOAD_WAIT = 2'(LOAD_LAT - 2);

    ctrl_state_t       state_q;
    logic [1:0]        dly_q;
    logic [iwidth-1:0] wcnt_q;
    logic [iwidth-1:0] wcnt_d;
    logic [iwidth-1:0] index_in_q;
    logic [iwidth-1:0] index_out_q;
    logic [dwidth-1:0] din_real_q;
    logic [dwidth-1:0] din_imag_q;
    logic              dv_in_q;
    logic              err_len_q;
    logic              out_valid_q;
    logic [cwidth-1:0] underrun_q;

    logic at_last;
    logic blocked;
    logic accept;
    logic bank_load;

    // The last sample triggers a bank load, so hold it back while a bank is in use.
    assign at_last   = (wcnt_q == LAST_IDX);
    assign blocked   = at_last && ((state_q == PLAY) || (state_q == LOADING));
    assign bus.s_ready = rst_n && !blocked;
    assign accept    = bus.s_valid && bus.s_ready;
    assign bank_load = accept && at_last;

    always_comb begin
        wcnt_d = wcnt_q;
        if (accept) begin
            wcnt_d = (bus.s_last && !at_last) ? '0 : wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q     <= '0;
            dv_in_q    <= 1'b0;
            err_len_q  <= 1'b0;
            index_in_q <= '0;
            din_real_q <= '0;
            din_imag_q <= '0;
        end else begin
            wcnt_q    <= wcnt_d;
            dv_in_q   <= accept;
            err_len_q <= accept && (bus.s_last != at_last);
            if (accept) begin
                index_in_q <= wcnt_q;
                din_real_q <= bus.s_real;
                din_imag_q <= bus.s_imag;
            end
        end
    end

    // Playout FSM; LOADING waits out linterp's bank_load and dout register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            dly_q       <= '0;
            index_out_q <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= '0;
        end else begin
            if (bus.out_strobe && ((state_q == LOADING) || (state_q == DRAIN))
                && (underrun_q != '1)) begin
                underrun_q <= underrun_q + 1'b1;
            end
            case (state_q)
                EMPTY, DRAIN: begin
                    if (bank_load) begin
                        state_q <= LOADING;
                        dly_q   <= '0;
                    end
                end
                LOADING: begin
                    if (dly_q == LOAD_WAIT) begin
                        state_q     <= PLAY;
                        out_valid_q <= 1'b1;
                        index_out_q <= '0;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.out_strobe) begin
                        if (index_out_q == LAST_IDX) begin
                            state_q     <= DRAIN;
                            index_out_q <= '0;
                            out_valid_q <= 1'b0;
                        end else begin
                            index_out_q <= index_out_q + 1'b1;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.dv_in        = dv_in_q;
    assign bus.index_in     = index_in_q;
    assign bus.din_real     = din_real_q;
    assign bus.din_imag     = din_imag_q;
    assign bus.index_out    = index_out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.err_len      = err_len_q;
    assign bus.underrun_cnt = underrun_q;

endmodule
